// File: rtl/eth_rt_rx_frame_check_pkg.sv
// Shared constants, state encoding and small helpers for the receive-path frame checker.
package eth_rt_rx_frame_check_pkg;

  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_FRAME = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // GMII delivers bit 0 first on the wire; the MSB-first CRC engine wants it in bit 7.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[7-i] = b[i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rt_rx_frame_check_crc32.sv
// Combinational CRC-32 (poly 04C11DB7, MSB first) advance by one byte; the state register lives in the caller.
module eth_rt_rx_frame_check_crc32
  import eth_rt_rx_frame_check_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c_s;
  logic        fb_s;

  always_comb begin
    c_s  = crc_i;
    fb_s = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb_s = c_s[31] ^ data_i[i];
      c_s  = {c_s[30:0], 1'b0} ^ (fb_s ? CRC32_POLY : 32'h0000_0000);
    end
    crc_o = c_s;
  end

endmodule

// File: rtl/eth_rt_rx_frame_check.sv
// Receive-path frame checker: latency-1 GMII forward, SFD search, CRC-32/length verdict and error counters.
// Optional build macro ETH_RX_STRIP_FCS_EN removes the 4 FCS bytes from the forwarded stream.
module eth_rt_rx_frame_check
  import eth_rt_rx_frame_check_pkg::*;
#(
  parameter int END_GAP = 3,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RxValid_in,
  input  logic [7:0]  RxD_in,
  input  logic        RxErr_in,
  input  logic        PortReady_in,
  output logic        PortReady_out,
  output logic        RxValid_out,
  output logic [7:0]  RxD_out,
  output logic        RxErr_out,
  input  logic        clearErrors,
  output logic        frame_done,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        len_err,
  output logic [11:0] frame_len,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] len_err_cnt
);

  localparam int                 GAP_W     = $clog2(END_GAP + 1);
  localparam logic [GAP_W-1:0]   END_GAP_W = GAP_W'(END_GAP);
  localparam logic [11:0]        MIN_LEN_W = 12'(MIN_LEN);
  localparam logic [11:0]        MAX_LEN_W = 12'(MAX_LEN);

  state_t            state_q, state_d;
  logic [31:0]       crc_q, crc_d, crc_next_s;
  logic [11:0]       len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              phy_err_q, phy_err_d;

  logic              sfd_hit_s, frame_byte_s, gap_idle_s, done_s;
  logic              crc_bad_s, len_bad_s;

  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rxd_q, rxd_d;
  logic              rx_err_q;
  logic              frame_done_q, frame_valid_q, crc_err_q, len_err_q;
  logic [11:0]       frame_len_q;
  logic [15:0]       crc_cnt_q, crc_cnt_d, len_cnt_q, len_cnt_d;

  eth_rt_rx_frame_check_crc32 u_crc32 (
    .crc_i  (crc_q),
    .data_i (bit_rev8(RxD_in)),
    .crc_o  (crc_next_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (RxValid_in && (RxD_in == SFD)) begin
          state_d = ST_FRAME;
        end else if (RxValid_in && (RxD_in == PREAMBLE_BYTE)) begin
          state_d = ST_PRE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (RxValid_in && (RxD_in == SFD)) begin
          state_d = ST_FRAME;
        end else begin
          state_d = ST_PRE;
        end
      end
      ST_FRAME: begin
        if (gap_q == END_GAP_W) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FRAME;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A stalled consumer (PortReady_in=0) must never be mistaken for the end-of-frame gap.
  always_comb begin
    sfd_hit_s    = 1'b0;
    frame_byte_s = 1'b0;
    gap_idle_s   = 1'b0;
    done_s       = 1'b0;
    case (state_q)
      ST_IDLE, ST_PRE: sfd_hit_s = RxValid_in && (RxD_in == SFD);
      ST_FRAME: begin
        frame_byte_s = RxValid_in && (gap_q != END_GAP_W);
        gap_idle_s   = !RxValid_in && PortReady_in;
      end
      ST_DONE:  done_s = 1'b1;
      default:  done_s = 1'b0;
    endcase
  end

  always_comb begin
    crc_d     = crc_q;
    len_d     = len_q;
    gap_d     = gap_q;
    phy_err_d = phy_err_q;
    if (sfd_hit_s) begin
      crc_d     = CRC32_INIT;
      len_d     = 12'd0;
      gap_d     = {GAP_W{1'b0}};
      phy_err_d = 1'b0;
    end else if (frame_byte_s) begin
      crc_d     = crc_next_s;
      len_d     = (len_q == 12'hFFF) ? len_q : len_q + 12'd1;
      gap_d     = {GAP_W{1'b0}};
      phy_err_d = phy_err_q | RxErr_in;
    end else if (gap_idle_s) begin
      gap_d     = (gap_q == END_GAP_W) ? gap_q : gap_q + GAP_W'(1);
      phy_err_d = phy_err_q | RxErr_in;
    end else if (done_s) begin
      gap_d     = {GAP_W{1'b0}};
    end else begin
      phy_err_d = phy_err_q | ((state_q == ST_FRAME) & RxErr_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= CRC32_INIT;
      len_q     <= 12'd0;
      gap_q     <= {GAP_W{1'b0}};
      phy_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      phy_err_q <= phy_err_d;
    end
  end

  assign crc_bad_s = (crc_q != CRC32_RESIDUE);
  assign len_bad_s = (len_q < MIN_LEN_W) | (len_q > MAX_LEN_W);

  // Clear beats a same-cycle increment so software sees a clean zero after clearing.
  always_comb begin
    crc_cnt_d = crc_cnt_q;
    len_cnt_d = len_cnt_q;
    if (clearErrors) begin
      crc_cnt_d = 16'd0;
      len_cnt_d = 16'd0;
    end else if (done_s) begin
      crc_cnt_d = crc_bad_s ? sat_inc16(crc_cnt_q) : crc_cnt_q;
      len_cnt_d = len_bad_s ? sat_inc16(len_cnt_q) : len_cnt_q;
    end else begin
      crc_cnt_d = crc_cnt_q;
      len_cnt_d = len_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      frame_len_q   <= 12'd0;
      crc_cnt_q     <= 16'd0;
      len_cnt_q     <= 16'd0;
    end else begin
      frame_done_q <= done_s;
      crc_cnt_q    <= crc_cnt_d;
      len_cnt_q    <= len_cnt_d;
      if (sfd_hit_s) begin
        frame_valid_q <= 1'b0;
        crc_err_q     <= 1'b0;
        len_err_q     <= 1'b0;
      end else if (done_s) begin
        frame_valid_q <= ~crc_bad_s & ~len_bad_s & ~phy_err_q;
        crc_err_q     <= crc_bad_s;
        len_err_q     <= len_bad_s;
        frame_len_q   <= len_q;
      end else begin
        frame_valid_q <= frame_valid_q;
        crc_err_q     <= crc_err_q;
        len_err_q     <= len_err_q;
      end
    end
  end

`ifdef ETH_RX_STRIP_FCS_EN
  logic [3:0][7:0] dline_q;
  logic [2:0]      fill_q;

  // Frame bytes lag by four so the trailing FCS is still in the line when the frame ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dline_q <= '0;
      fill_q  <= 3'd0;
    end else if (sfd_hit_s || done_s) begin
      dline_q <= '0;
      fill_q  <= 3'd0;
    end else if (frame_byte_s) begin
      dline_q <= {dline_q[2:0], RxD_in};
      fill_q  <= (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
    end else begin
      dline_q <= dline_q;
      fill_q  <= fill_q;
    end
  end

  always_comb begin
    rx_valid_d = RxValid_in;
    rxd_d      = RxD_in;
    if (state_q == ST_FRAME) begin
      rx_valid_d = frame_byte_s && (fill_q == 3'd4);
      rxd_d      = dline_q[3];
    end else begin
      rx_valid_d = RxValid_in;
      rxd_d      = RxD_in;
    end
  end
`else
  assign rx_valid_d = RxValid_in;
  assign rxd_d      = RxD_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rxd_q      <= 8'h00;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rxd_q      <= rxd_d;
      rx_err_q   <= RxErr_in;
    end
  end

  assign PortReady_out = PortReady_in;
  assign RxValid_out   = rx_valid_q;
  assign RxD_out       = rxd_q;
  assign RxErr_out     = rx_err_q;
  assign frame_done    = frame_done_q;
  assign frame_valid   = frame_valid_q;
  assign crc_err       = crc_err_q;
  assign len_err       = len_err_q;
  assign frame_len     = frame_len_q;
  assign crc_err_cnt   = crc_cnt_q;
  assign len_err_cnt   = len_cnt_q;

endmodule

// File: tb/tb_eth_rt_rx_frame_check.sv
// Directed self-checking bench for eth_rt_rx_frame_check; honours ETH_RX_STRIP_FCS_EN when defined.
module tb_eth_rt_rx_frame_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        RxValid_in, RxErr_in, PortReady_in, clearErrors;
  logic [7:0]  RxD_in;
  logic        PortReady_out, RxValid_out, RxErr_out;
  logic [7:0]  RxD_out;
  logic        frame_done, frame_valid, crc_err, len_err;
  logic [11:0] frame_len;
  logic [15:0] crc_err_cnt, len_err_cnt;

  always #5 clk = ~clk;

  eth_rt_rx_frame_check dut (
    .clk(clk), .rst(rst),
    .RxValid_in(RxValid_in), .RxD_in(RxD_in), .RxErr_in(RxErr_in),
    .PortReady_in(PortReady_in), .PortReady_out(PortReady_out),
    .RxValid_out(RxValid_out), .RxD_out(RxD_out), .RxErr_out(RxErr_out),
    .clearErrors(clearErrors), .frame_done(frame_done), .frame_valid(frame_valid),
    .crc_err(crc_err), .len_err(len_err), .frame_len(frame_len),
    .crc_err_cnt(crc_err_cnt), .len_err_cnt(len_err_cnt)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fb[$];
  logic [7:0] out_q[$];
  logic       mon_en = 1'b0;
  logic       collecting = 1'b0;
  int         done_cnt = 0;
  logic       prev_v = 1'b0, prev_e = 1'b0;
  logic [7:0] prev_d = 8'h00;

  // Frame body plus Ethernet FCS computed with the reflected algorithm; flip corrupts one byte afterwards.
  task automatic build(input int n_data, input int flip_idx);
    logic [31:0] c;
    fb.delete();
    for (int i = 0; i < n_data; i++) fb.push_back(8'(i * 37 + 11));
    c = 32'hFFFF_FFFF;
    foreach (fb[i]) begin
      c = c ^ {24'h000000, fb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    if (flip_idx >= 0) fb[flip_idx] = fb[flip_idx] ^ 8'h01;
    fb.push_back(c[7:0]);
    fb.push_back(c[15:8]);
    fb.push_back(c[23:16]);
    fb.push_back(c[31:24]);
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic e, input logic pr);
    @(posedge clk);
    #1;
    RxValid_in   = v;
    RxD_in       = d;
    RxErr_in     = e;
    PortReady_in = pr;
  endtask

  task automatic send(input int pre_n, input int gap_every, input int stall_at,
                      input int err_at, input int rst_at);
    out_q.delete();
    for (int i = 0; i < pre_n; i++) drv(1'b1, 8'h55, 1'b0, 1'b1);
    drv(1'b1, 8'hD5, 1'b0, 1'b1);
    for (int i = 0; i < fb.size(); i++) begin
      if (i == rst_at) begin
        drv(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b1;
        drv(1'b0, 8'h00, 1'b0, 1'b1);
        drv(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b0;
        break;
      end
      if (i == stall_at) repeat (20) drv(1'b0, 8'h00, 1'b0, 1'b0);
      drv(1'b1, fb[i], (i == err_at), 1'b1);
      if (gap_every > 0 && (i % gap_every) == gap_every - 1) drv(1'b0, 8'h00, 1'b0, 1'b1);
    end
    repeat (16) drv(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic verdict(input string tag, input int d0, input int exp_done, input logic ev,
                         input logic ec, input logic el, input int exp_len,
                         input int exp_ccnt, input int exp_lcnt);
    @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(exp_done));
    chk({tag, "_frame_valid"}, {31'd0, frame_valid}, {31'd0, ev});
    chk({tag, "_crc_err"}, {31'd0, crc_err}, {31'd0, ec});
    chk({tag, "_len_err"}, {31'd0, len_err}, {31'd0, el});
    chk({tag, "_frame_len"}, {20'd0, frame_len}, 32'(exp_len));
    chk({tag, "_crc_err_cnt"}, {16'd0, crc_err_cnt}, 32'(exp_ccnt));
    chk({tag, "_len_err_cnt"}, {16'd0, len_err_cnt}, 32'(exp_lcnt));
  endtask

  // Output monitor: latency-1 forward check, frame_done pulse count, forwarded frame bytes.
  always @(negedge clk) begin
    if (rst) begin
      prev_v     = 1'b0;
      prev_d     = 8'h00;
      prev_e     = 1'b0;
      collecting = 1'b0;
    end else begin
`ifndef ETH_RX_STRIP_FCS_EN
      if (mon_en) begin
        chk("lat_valid", {31'd0, RxValid_out}, {31'd0, prev_v});
        chk("lat_data", {24'd0, RxD_out}, {24'd0, prev_d});
        chk("lat_err", {31'd0, RxErr_out}, {31'd0, prev_e});
      end
`endif
      prev_v = RxValid_in;
      prev_d = RxD_in;
      prev_e = RxErr_in;
      if (frame_done) done_cnt++;
      if (RxValid_out) begin
        if (collecting) out_q.push_back(RxD_out);
        else if (RxD_out == 8'hD5) collecting = 1'b1;
      end
      if (frame_done) collecting = 1'b0;
    end
  end

  initial begin
    int d0;
    int exp_n;
    rst = 1'b1;
    RxValid_in = 1'b0; RxD_in = 8'h00; RxErr_in = 1'b0;
    PortReady_in = 1'b0; clearErrors = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_valid", {31'd0, RxValid_out}, 32'd0);
    chk("rst_rxd", {24'd0, RxD_out}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_frame_len", {20'd0, frame_len}, 32'd0);
    chk("rst_crc_cnt", {16'd0, crc_err_cnt}, 32'd0);
    chk("rst_port_ready_lo", {31'd0, PortReady_out}, 32'd0);
    PortReady_in = 1'b1;
    #1;
    chk("rst_port_ready_hi", {31'd0, PortReady_out}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: good 64-byte frame
    build(60, -1);
    d0 = done_cnt;
    send(7, 0, -1, -1, -1);
    verdict("t1", d0, 1, 1'b1, 1'b0, 1'b0, 64, 0, 0);
`ifdef ETH_RX_STRIP_FCS_EN
    exp_n = 60;
`else
    exp_n = 64;
`endif
    chk("t1_fwd_count", 32'(out_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < out_q.size(); i++)
      chk($sformatf("t1_fwd_byte%0d", i), {24'd0, out_q[i]}, {24'd0, fb[i]});

    // 2: corrupted data byte 10
    build(60, 10);
    d0 = done_cnt;
    send(7, 0, -1, -1, -1);
    verdict("t2", d0, 1, 1'b0, 1'b1, 1'b0, 64, 1, 0);

    // 3: short frame, good FCS
    build(40, -1);
    d0 = done_cnt;
    send(7, 0, -1, -1, -1);
    verdict("t3", d0, 1, 1'b0, 1'b0, 1'b1, 44, 1, 1);

    // 4: gaps between bytes and a 20-cycle consumer stall
    build(60, -1);
    d0 = done_cnt;
    send(7, 5, 30, -1, -1);
    verdict("t4", d0, 1, 1'b1, 1'b0, 1'b0, 64, 1, 1);

    // 5a: GMII error inside an otherwise good frame
    build(60, -1);
    d0 = done_cnt;
    send(7, 0, -1, 30, -1);
    verdict("t5a", d0, 1, 1'b0, 1'b0, 1'b0, 64, 1, 1);

    // 5b: reset mid-frame abandons it and clears the counters
    d0 = done_cnt;
    send(7, 0, -1, -1, 20);
    verdict("t5b", d0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    // clearErrors held across a bad frame: the clear wins over the increment
    build(60, 10);
    clearErrors = 1'b1;
    d0 = done_cnt;
    send(7, 0, -1, -1, -1);
    verdict("clr_win", d0, 1, 1'b0, 1'b1, 1'b0, 64, 0, 0);
    clearErrors = 1'b0;

    // short preamble (2 bytes) still locks; bad CRC counted
    d0 = done_cnt;
    send(2, 0, -1, -1, -1);
    verdict("short_pre", d0, 1, 1'b0, 1'b1, 1'b0, 64, 1, 0);

    // one-cycle clear pulse
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    clearErrors = 1'b1;
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    clearErrors = 1'b0;
    @(negedge clk);
    chk("clr_pulse_crc_cnt", {16'd0, crc_err_cnt}, 32'd0);
    chk("clr_held_crc_err", {31'd0, crc_err}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
